// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-memory wait freezes with a timeout trap, and saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int INIT_BUBBLES = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic             IF_ID_Uses_RS2,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_MemRead,
    input  logic             EX_Branch_Taken,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic             Fault,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int INIT_W = (INIT_BUBBLES > 1) ? $clog2(INIT_BUBBLES + 1) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_BUBBLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_FAULT
    } state_t;

    state_t            state, state_next;
    logic [INIT_W-1:0] init_cnt, init_cnt_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic              fault_q, fault_next;
    logic              mem_wait, load_use, flush_event;

    assign mem_wait = MEM_Req & ~MEM_Ready;
    assign load_use = ID_EX_MemRead & (ID_EX_RD != 5'd0) &
                      ((ID_EX_RD == IF_ID_RS1) | (IF_ID_Uses_RS2 & (ID_EX_RD == IF_ID_RS2)));
    assign Fault    = fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            wait_cnt <= wait_cnt_next;
            fault_q  <= fault_next;
        end
    end

    // Default is the full freeze; each state overrides only what it releases.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        wait_cnt_next = wait_cnt;
        fault_next    = fault_q;
        flush_event   = 1'b0;
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;
        case (state)
            ST_INIT: begin
                IF_ID_Flush   = 1'b1;
                ID_EX_Write   = 1'b1;
                ID_EX_Flush   = 1'b1;
                EX_MEM_Write  = 1'b1;
                MEM_WB_Bubble = 1'b0;
                if (init_cnt == INIT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    init_cnt_next = init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (mem_wait) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end else begin
                    MEM_WB_Bubble = 1'b0;
                    ID_EX_Write   = 1'b1;
                    EX_MEM_Write  = 1'b1;
                    if (EX_Branch_Taken) begin
                        PC_Write    = 1'b1;
                        IF_ID_Write = 1'b1;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        flush_event = 1'b1;
                    end else if (load_use) begin
                        ID_EX_Flush = 1'b1;
                    end else begin
                        PC_Write    = 1'b1;
                        IF_ID_Write = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Release ignores the frozen branch/load-use; RUN re-evaluates them next cycle.
                if (MEM_Ready) begin
                    PC_Write      = 1'b1;
                    IF_ID_Write   = 1'b1;
                    ID_EX_Write   = 1'b1;
                    EX_MEM_Write  = 1'b1;
                    MEM_WB_Bubble = 1'b0;
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_ONE;
                    if (wait_cnt >= WAIT_LAST) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                fault_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if ((state == ST_RUN || state == ST_MEM_WAIT) && !PC_Write && (Stall_Count != '1)) begin
                Stall_Count <= Stall_Count + CNT_W'(1);
            end
            if (flush_event && (Flush_Count != '1)) begin
                Flush_Count <= Flush_Count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed per-cycle vectors push expected
// controls and counts; a monitor pops and compares at each falling edge.
module tb_pipeline_hazard_controller;

    localparam logic [7:0] C_INIT    = 8'b0011_1100;
    localparam logic [7:0] C_NONE    = 8'b1101_0100;
    localparam logic [7:0] C_LU      = 8'b0001_1100;
    localparam logic [7:0] C_BRANCH  = 8'b1111_1100;
    localparam logic [7:0] C_FREEZE  = 8'b0000_0010;
    localparam logic [7:0] C_RELEASE = 8'b1101_0100;
    localparam logic [7:0] C_FAULT   = 8'b0000_0011;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       taken;
        logic       req;
        logic       ready;
    } stim_t;

    typedef struct {
        string      name;
        logic [7:0] ctrl;
        int         stall;
        int         flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
    logic        if_id_uses_rs2 = 1'b0, id_ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, mem_wb_bubble, fault;
    logic [15:0] stall_count, flush_count;

    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4;
    logic        ex_mem_write4, mem_wb_bubble4, fault4;
    logic [3:0]  stall_count4, flush_count4;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .reset(reset),
        .IF_ID_RS1(if_id_rs1), .IF_ID_RS2(if_id_rs2), .IF_ID_Uses_RS2(if_id_uses_rs2),
        .ID_EX_RD(id_ex_rd), .ID_EX_MemRead(id_ex_mem_read), .EX_Branch_Taken(ex_branch_taken),
        .MEM_Req(mem_req), .MEM_Ready(mem_ready),
        .PC_Write(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
        .ID_EX_Write(id_ex_write), .ID_EX_Flush(id_ex_flush), .EX_MEM_Write(ex_mem_write),
        .MEM_WB_Bubble(mem_wb_bubble), .Fault(fault),
        .Stall_Count(stall_count), .Flush_Count(flush_count)
    );

    pipeline_hazard_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .IF_ID_RS1(if_id_rs1), .IF_ID_RS2(if_id_rs2), .IF_ID_Uses_RS2(if_id_uses_rs2),
        .ID_EX_RD(id_ex_rd), .ID_EX_MemRead(id_ex_mem_read), .EX_Branch_Taken(ex_branch_taken),
        .MEM_Req(mem_req), .MEM_Ready(mem_ready),
        .PC_Write(pc_write4), .IF_ID_Write(if_id_write4), .IF_ID_Flush(if_id_flush4),
        .ID_EX_Write(id_ex_write4), .ID_EX_Flush(id_ex_flush4), .EX_MEM_Write(ex_mem_write4),
        .MEM_WB_Bubble(mem_wb_bubble4), .Fault(fault4),
        .Stall_Count(stall_count4), .Flush_Count(flush_count4)
    );

    function automatic stim_t mk(input logic rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic uses, input logic [4:0] rd, input logic mem_read,
                                 input logic taken, input logic req, input logic ready);
        stim_t s;
        s.rst_n    = rst_n;
        s.rs1      = rs1;
        s.rs2      = rs2;
        s.uses_rs2 = uses;
        s.rd       = rd;
        s.mem_read = mem_read;
        s.taken    = taken;
        s.req      = req;
        s.ready    = ready;
        return s;
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic apply_stimulus(input string name, input stim_t s, input logic [7:0] ctrl,
                                  input int stall, input int flush);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = s.rst_n;
        if_id_rs1       = s.rs1;
        if_id_rs2       = s.rs2;
        if_id_uses_rs2  = s.uses_rs2;
        id_ex_rd        = s.rd;
        id_ex_mem_read  = s.mem_read;
        ex_branch_taken = s.taken;
        mem_req         = s.req;
        mem_ready       = s.ready;
        e.name  = name;
        e.ctrl  = ctrl;
        e.stall = stall;
        e.flush = flush;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input string name, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
        end
    endtask

    task automatic check_output(input exp_t e);
        logic [7:0] act;
        act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, fault};
        checks++;
        if (act !== e.ctrl) begin
            failures++;
            $display("[TB] FAIL %s.ctrl actual=%b required=%b", e.name, act, e.ctrl);
        end
        check_val(e.name, "stall", int'(stall_count), e.stall);
        check_val(e.name, "flush", int'(flush_count), e.flush);
        check_val(e.name, "stall4", int'(stall_count4), sat15(e.stall));
        check_val(e.name, "flush4", int'(flush_count4), sat15(e.flush));
    endtask

    // Monitor: one expected entry per stimulus cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic reset_seq();
        apply_stimulus("rst_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), C_INIT, 0, 0);
        for (int i = 0; i < 3; i++)
            apply_stimulus($sformatf("init%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, 0), C_INIT, 0, 0);
    endtask

    initial begin
        stim_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

        reset_seq();
        apply_stimulus("run0", idle, C_NONE, 0, 0);
        apply_stimulus("run1", idle, C_NONE, 0, 0);

        apply_stimulus("lu_rs1", mk(1, 5, 2, 0, 5, 1, 0, 0, 0), C_LU, 0, 0);
        apply_stimulus("lu_after", mk(1, 5, 2, 0, 0, 0, 0, 0, 0), C_NONE, 1, 0);
        apply_stimulus("lu_rd0", mk(1, 0, 0, 1, 0, 1, 0, 0, 0), C_NONE, 1, 0);
        apply_stimulus("lu_rs2", mk(1, 3, 7, 1, 7, 1, 0, 0, 0), C_LU, 1, 0);
        apply_stimulus("rs2_unused", mk(1, 3, 7, 0, 7, 1, 0, 0, 0), C_NONE, 2, 0);
        apply_stimulus("idle_b", idle, C_NONE, 2, 0);

        reset_seq();
        apply_stimulus("lu_branch", mk(1, 5, 0, 0, 5, 1, 1, 0, 0), C_BRANCH, 0, 0);
        apply_stimulus("post_branch", idle, C_NONE, 0, 1);
        apply_stimulus("mw_over_br", mk(1, 0, 0, 0, 0, 0, 1, 1, 0), C_FREEZE, 0, 1);
        apply_stimulus("rel_ign_br", mk(1, 5, 0, 0, 5, 1, 1, 1, 1), C_RELEASE, 1, 1);
        apply_stimulus("br_reeval", mk(1, 0, 0, 0, 0, 0, 1, 0, 0), C_BRANCH, 1, 1);
        apply_stimulus("idle_c", idle, C_NONE, 1, 2);

        reset_seq();
        for (int k = 1; k <= 4; k++)
            apply_stimulus($sformatf("wait4_%0d", k), mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FREEZE, k - 1, 0);
        apply_stimulus("wait4_rel", mk(1, 0, 0, 0, 0, 0, 0, 1, 1), C_RELEASE, 4, 0);
        apply_stimulus("req_ready", mk(1, 0, 0, 0, 0, 0, 0, 1, 1), C_NONE, 4, 0);
        apply_stimulus("idle_d", idle, C_NONE, 4, 0);
        apply_stimulus("wait_a", mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FREEZE, 4, 0);
        apply_stimulus("wait_b", mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FREEZE, 5, 0);

        reset_seq();
        for (int k = 1; k <= 15; k++)
            apply_stimulus($sformatf("edge_%0d", k), mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FREEZE, k - 1, 0);
        apply_stimulus("edge_ready", mk(1, 0, 0, 0, 0, 0, 0, 1, 1), C_RELEASE, 15, 0);
        apply_stimulus("edge_run", idle, C_NONE, 15, 0);

        reset_seq();
        for (int k = 1; k <= 16; k++)
            apply_stimulus($sformatf("to_%0d", k), mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FREEZE, k - 1, 0);
        apply_stimulus("fault17", mk(1, 0, 0, 0, 0, 0, 0, 1, 0), C_FAULT, 16, 0);
        apply_stimulus("fault_rdy", mk(1, 5, 0, 0, 5, 1, 1, 1, 1), C_FAULT, 16, 0);
        apply_stimulus("fault_idle", idle, C_FAULT, 16, 0);

        reset_seq();
        for (int k = 1; k <= 20; k++)
            apply_stimulus($sformatf("br_%0d", k), mk(1, 0, 0, 0, 0, 0, 1, 0, 0), C_BRANCH, 0, k - 1);
        apply_stimulus("sat_idle", idle, C_NONE, 0, 20);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
